// File: rtl/rect_to_polar_mux_if.sv
// Frame-level valid/ready bundle for the rectangular-to-polar converter.
// The converter sits on the slave side; the producer/consumer sits on the master side.
interface rect_to_polar_mux_if #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32
);
  logic [CHANNELS*DATA_WIDTH-1:0] data_in;
  logic                           valid_in;
  logic                           ready_out;
  logic [DATA_WIDTH-1:0]          data_out [CHANNELS];
  logic                           valid_out;
  logic                           ready_in;

  modport slave (
    input  data_in, valid_in, ready_in,
    output ready_out, data_out, valid_out
  );

  modport master (
    output data_in, valid_in, ready_in,
    input  ready_out, data_out, valid_out
  );
endinterface

// File: rtl/rect_to_polar_mux.sv
// Time-multiplexed rectangular-to-polar converter: one shared vectoring-mode CORDIC
// engine walks every channel of a latched frame and returns {phase, magnitude} per channel.
module rect_to_polar_mux #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ITERATIONS = 14
) (
  input logic               clk_in,
  input logic               rst_in,
  rect_to_polar_mux_if.slave bus
);
  localparam int H  = DATA_WIDTH / 2;
  localparam int W  = H + 2;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, ITER, STORE, DONE} state_t;

  // atan(2^-i) as a 32-bit binary angle where 2^31 represents pi.
  function automatic logic [31:0] atan_rom(input int idx);
    case (idx)
      0:  return 32'h2000_0000;
      1:  return 32'h12E4_051E;
      2:  return 32'h09FB_385B;
      3:  return 32'h0511_11D4;
      4:  return 32'h028B_0D43;
      5:  return 32'h0145_D7E1;
      6:  return 32'h00A2_F61E;
      7:  return 32'h0051_7C55;
      8:  return 32'h0028_BE53;
      9:  return 32'h0014_5F2F;
      10: return 32'h000A_2F98;
      11: return 32'h0005_17CC;
      12: return 32'h0002_8BE6;
      13: return 32'h0001_45F3;
      14: return 32'h0000_A2FA;
      15: return 32'h0000_517D;
      16: return 32'h0000_28BE;
      17: return 32'h0000_145F;
      18: return 32'h0000_0A30;
      19: return 32'h0000_0518;
      20: return 32'h0000_028C;
      21: return 32'h0000_0146;
      22: return 32'h0000_00A3;
      23: return 32'h0000_0051;
      24: return 32'h0000_0029;
      25: return 32'h0000_0014;
      26: return 32'h0000_000A;
      27: return 32'h0000_0005;
      28: return 32'h0000_0003;
      29: return 32'h0000_0001;
      30: return 32'h0000_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Round-to-nearest reduction of the 32-bit angle to H bits; the appended
  // half-LSB bit keeps the H == 32 case a plain pass-through.
  function automatic logic [H-1:0] round_angle(input logic [31:0] a);
    logic [32:0] t;
    t = {a, 1'b0} + (33'd1 << (32 - H));
    return t[32 -: H];
  endfunction

  state_t                state_reg;
  logic [CW-1:0]         ch_reg;
  logic [IW-1:0]         iter_reg;
  logic signed [W-1:0]   x_reg, y_reg;
  logic [H-1:0]          z_reg;
  logic                  zero_reg;
  logic                  valid_reg;
  logic                  ready_reg;
  logic [DATA_WIDTH-1:0] out_reg   [CHANNELS];
  logic [DATA_WIDTH-1:0] frame_reg [CHANNELS];
  logic [H-1:0]          angle_tab [ITERATIONS];

  logic                  accept;
  logic [DATA_WIDTH-1:0] sample;
  logic signed [W-1:0]   re_ext, im_ext;
  logic [H-1:0]          angle;
  logic signed [W-1:0]   x_shift, y_shift;
  logic signed [W-1:0]   x_next, y_next;
  logic [H-1:0]          z_next;

  genvar gi;
  generate
    for (gi = 0; gi < ITERATIONS; gi++) begin : g_angle
      assign angle_tab[gi] = round_angle(atan_rom(gi));
    end
    for (gi = 0; gi < CHANNELS; gi++) begin : g_out
      assign bus.data_out[gi] = out_reg[gi];
    end
  endgenerate

  assign bus.ready_out = ready_reg;
  assign bus.valid_out = valid_reg;
  assign accept        = (state_reg == IDLE) && ready_reg && bus.valid_in;

  assign sample = frame_reg[ch_reg];
  assign re_ext = W'($signed(sample[H-1:0]));
  assign im_ext = W'($signed(sample[DATA_WIDTH-1:H]));
  assign angle  = angle_tab[iter_reg];

  // One micro-rotation; every right-hand side uses the pre-step values.
  always_comb begin
    x_shift = x_reg >>> iter_reg;
    y_shift = y_reg >>> iter_reg;
    x_next  = x_reg;
    y_next  = y_reg;
    z_next  = z_reg;
    if (!y_reg[W-1]) begin
      x_next = x_reg + y_shift;
      y_next = y_reg - x_shift;
      z_next = z_reg + angle;
    end else begin
      x_next = x_reg - y_shift;
      y_next = y_reg + x_shift;
      z_next = z_reg - angle;
    end
  end

  // Frame buffer has no reset: it is only read after a handshake has filled it.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        frame_reg[c] <= bus.data_in[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= IDLE;
      ch_reg    <= '0;
      iter_reg  <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      zero_reg  <= 1'b0;
      valid_reg <= 1'b0;
      ready_reg <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        out_reg[c] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg <= LOAD;
            ch_reg    <= '0;
            ready_reg <= 1'b0;
          end else begin
            ready_reg <= 1'b1;
          end
        end
        LOAD: begin
          // Fold the left half-plane onto the right by a pi pre-rotation.
          if (re_ext < 0) begin
            x_reg <= -re_ext;
            y_reg <= -im_ext;
            z_reg <= {1'b1, {(H-1){1'b0}}};
          end else begin
            x_reg <= re_ext;
            y_reg <= im_ext;
            z_reg <= '0;
          end
          zero_reg  <= (re_ext == 0) && (im_ext == 0);
          iter_reg  <= '0;
          state_reg <= ITER;
        end
        ITER: begin
          x_reg <= x_next;
          y_reg <= y_next;
          z_reg <= z_next;
          if (iter_reg == IW'(ITERATIONS - 1)) begin
            state_reg <= STORE;
          end else begin
            iter_reg <= iter_reg + 1'b1;
          end
        end
        STORE: begin
          out_reg[ch_reg] <= zero_reg ? '0 : {z_reg, x_reg[H:1]};
          if (ch_reg == CW'(CHANNELS - 1)) begin
            state_reg <= DONE;
            valid_reg <= 1'b1;
          end else begin
            ch_reg    <= ch_reg + 1'b1;
            state_reg <= LOAD;
          end
        end
        DONE: begin
          if (bus.ready_in) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rect_to_polar_mux.sv
// Directed bench for rect_to_polar_mux: axis/quadrant vectors, zero channel, latency,
// backpressure, back-to-back frames and asynchronous reset mid-frame.
module tb_rect_to_polar_mux;
  localparam int CH = 4;
  localparam int DW = 32;
  localparam int IT = 14;
  localparam int LAT = CH * (IT + 2);

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk_in = ~clk_in;

  rect_to_polar_mux_if #(.CHANNELS(CH), .DATA_WIDTH(DW)) bus ();

  rect_to_polar_mux #(.CHANNELS(CH), .DATA_WIDTH(DW), .ITERATIONS(IT)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  function automatic logic [31:0] pk(input int re, input int im);
    logic [15:0] r, i;
    r = re[15:0];
    i = im[15:0];
    return {i, r};
  endfunction

  function automatic logic [127:0] frame(input int r0, i0, r1, i1, r2, i2, r3, i3);
    return {pk(r3, i3), pk(r2, i2), pk(r1, i1), pk(r0, i0)};
  endfunction

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_mag(input string tag, input int c, input int exp, input int tol);
    int  obs;
    logic ok;
    obs = int'(bus.data_out[c][15:0]);
    ok  = (obs - exp <= tol) && (exp - obs <= tol);
    total++;
    assert (ok === 1'b1)
    else begin
      bad++;
      $error("FAIL %s magnitude observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  // Circular comparison: the difference is taken modulo 2^16.
  task automatic check_phase(input string tag, input int c, input int exp, input int tol);
    logic [15:0] e16, d;
    int          diff;
    logic        ok;
    e16  = exp[15:0];
    d    = bus.data_out[c][31:16] - e16;
    diff = int'($signed(d));
    ok   = (diff <= tol) && (diff >= -tol);
    total++;
    assert (ok === 1'b1)
    else begin
      bad++;
      $error("FAIL %s phase observed=%0d expected=%0d+-%0d", tag,
             int'($signed(bus.data_out[c][31:16])), $signed(e16), tol);
    end
  endtask

  task automatic send_frame(input logic [127:0] f);
    int n;
    n = 0;
    bus.data_in  = f;
    bus.valid_in = 1'b1;
    while (!bus.ready_out && n < 50) begin
      cyc();
      n++;
    end
    check_eq("ready_before_accept", bus.ready_out, 1);
    cyc();
    bus.valid_in = 1'b0;
    $display("frame accepted data_in=%h", f);
  endtask

  // Called 1 time unit after the accept edge; counts edges until valid_out rises.
  task automatic wait_valid(input bit poke);
    int lat, ready_seen;
    lat = 0;
    ready_seen = 0;
    while (!bus.valid_out && lat < 200) begin
      cyc();
      lat++;
      if (bus.ready_out) ready_seen++;
      if (poke && lat == 10) begin
        bus.data_in  = frame(1000, 2000, 3000, 4000, 5000, 6000, 7000, 8000);
        bus.valid_in = 1'b1;
      end
      if (poke && lat == 12) bus.valid_in = 1'b0;
    end
    check_eq("latency", lat, LAT);
    check_eq("ready_low_during_frame", ready_seen, 0);
    $display("valid_out after %0d cycles", lat);
  endtask

  task automatic finish_handshake();
    bus.ready_in = 1'b1;
    cyc();
    bus.ready_in = 1'b0;
    check_eq("valid_drop_after_handshake", bus.valid_out, 0);
    check_eq("ready_rise_after_handshake", bus.ready_out, 1);
  endtask

  logic [31:0] snap [CH];
  int          changed;
  int          valid_drop;
  int          ready_high;

  initial begin
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b0;

    // Reset state
    cyc();
    cyc();
    check_eq("reset_ready", bus.ready_out, 0);
    check_eq("reset_valid", bus.valid_out, 0);
    for (int c = 0; c < CH; c++) check_eq("reset_data", bus.data_out[c], 0);
    rst_in = 1'b0;

    // Frame A: axes, zero on channel 2, negative real axis; junk poked mid-frame
    send_frame(frame(16384, 0, 0, 16384, 0, 0, -16384, 0));
    wait_valid(1'b1);
    check_mag  ("A0_re_axis", 0, 13491, 3);
    check_phase("A0_re_axis", 0, 0, 2);
    check_mag  ("A1_im_axis", 1, 13491, 3);
    check_phase("A1_im_axis", 1, 16384, 2);
    check_eq   ("A2_zero", bus.data_out[2], 0);
    check_mag  ("A3_neg_re", 3, 13491, 3);
    check_phase("A3_neg_re", 3, 32768, 2);
    $display("frame A out: %h %h %h %h", bus.data_out[0], bus.data_out[1],
             bus.data_out[2], bus.data_out[3]);

    // Backpressure for 20 cycles, with the next frame already offered
    for (int c = 0; c < CH; c++) snap[c] = bus.data_out[c];
    bus.data_in  = frame(-32768, -32768, 0, -16384, 16384, 16384, 16384, 0);
    bus.valid_in = 1'b1;
    changed = 0;
    valid_drop = 0;
    ready_high = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      for (int c = 0; c < CH; c++) if (bus.data_out[c] !== snap[c]) changed++;
      if (!bus.valid_out) valid_drop++;
      if (bus.ready_out) ready_high++;
    end
    check_eq("bp_data_stable", changed, 0);
    check_eq("bp_valid_held", valid_drop, 0);
    check_eq("bp_no_accept_in_done", ready_high, 0);
    $display("backpressure held 20 cycles");

    // Output handshake with valid_in still high; frame B accepted in the next IDLE
    finish_handshake();
    cyc();
    bus.valid_in = 1'b0;
    check_eq("B_accepted", bus.ready_out, 0);
    wait_valid(1'b0);
    check_mag  ("B0_q3", 0, 38155, 4);
    check_phase("B0_q3", 0, -24576, 2);
    check_mag  ("B1_neg_im", 1, 13491, 3);
    check_phase("B1_neg_im", 1, -16384, 2);
    check_mag  ("B2_diag", 2, 19078, 4);
    check_phase("B2_diag", 2, 8192, 2);
    check_mag  ("B3_re_axis", 3, 13491, 3);
    check_phase("B3_re_axis", 3, 0, 2);
    $display("frame B out: %h %h %h %h", bus.data_out[0], bus.data_out[1],
             bus.data_out[2], bus.data_out[3]);
    finish_handshake();

    // Reset mid-frame
    send_frame(frame(12000, -5000, 12000, -5000, 12000, -5000, 12000, -5000));
    for (int k = 0; k < 29; k++) cyc();
    rst_in = 1'b1;
    #1;
    check_eq("midrst_valid", bus.valid_out, 0);
    check_eq("midrst_ready", bus.ready_out, 0);
    for (int c = 0; c < CH; c++) check_eq("midrst_data", bus.data_out[c], 0);
    $display("reset asserted mid-frame");
    cyc();
    rst_in = 1'b0;

    // Frame D after reset
    send_frame(frame(-16384, 0, 16384, 0, 0, -16384, 16384, 16384));
    wait_valid(1'b0);
    check_mag  ("D0_neg_re", 0, 13491, 3);
    check_phase("D0_neg_re", 0, 32768, 2);
    check_mag  ("D1_re_axis", 1, 13491, 3);
    check_phase("D1_re_axis", 1, 0, 2);
    check_mag  ("D2_neg_im", 2, 13491, 3);
    check_phase("D2_neg_im", 2, -16384, 2);
    check_mag  ("D3_diag", 3, 19078, 4);
    check_phase("D3_diag", 3, 8192, 2);
    $display("frame D out: %h %h %h %h", bus.data_out[0], bus.data_out[1],
             bus.data_out[2], bus.data_out[3]);
    finish_handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
